dvs_event_fifo: RTL and testbench

//  Elastic buffer directly downstream of the DVS AER receiver. Captures each decoded event
//  {x, y, timestamp_us, polarity} on a one-cycle strobe, stores it in a FIFO and presents it
//  to the RAVENS-side consumer over a valid/ready handshake. Absorbs camera bursts, drops

---
 rtl/dvs_ravens_pkg.sv | 16 +
 rtl/dvs_event_fifo.sv | 109 ++++++++++
 tb/tb_dvs_event_fifo.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/dvs_ravens_pkg.sv
// Shared DVS/RAVENS definitions: event field widths and the packed event word.
package dvs_ravens_pkg;

  localparam int DVS_X_ADDR_BITS   = 9;
  localparam int DVS_Y_ADDR_BITS   = 9;
  localparam int TIMESTAMP_US_BITS = 32;

  // Storage/transport word, MSB..LSB = {x, y, timestamp, polarity}
  typedef struct packed {
    logic [DVS_X_ADDR_BITS-1:0]   x;
    logic [DVS_Y_ADDR_BITS-1:0]   y;
    logic [TIMESTAMP_US_BITS-1:0] ts;
    logic                         pol;
  } dvs_event_t;

endpackage

// File: rtl/dvs_event_fifo.sv
// dvs_event_fifo: elastic buffer between the DVS AER receiver and the RAVENS
// consumer.
//
// Each decoded event, strobed by in_valid, is written into a FIFO of
// FIFO_DEPTH entries. The head entry is presented show-ahead on
// out_valid/out_ready. An event that arrives while the FIFO is full and
// nothing is popped is discarded and counted in a saturating drop counter.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid, in_x/y/timestamp/polarity   one-cycle event strobe + fields
//   out_ready                       consumer takes the head entry this cycle
//   out_valid, out_x/y/timestamp/polarity head entry (registered)
//   fill_level                      occupancy, 0..FIFO_DEPTH
//   full                            fill_level == FIFO_DEPTH
//   drop_count                      saturating count of discarded events
//   clear_drops                     synchronous clear of drop_count
module dvs_event_fifo
  import dvs_ravens_pkg::*;
#(
  parameter int FIFO_DEPTH    = 16,
  parameter int DROP_CNT_BITS = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  input  logic [DVS_X_ADDR_BITS-1:0]       in_x,
  input  logic [DVS_Y_ADDR_BITS-1:0]       in_y,
  input  logic [TIMESTAMP_US_BITS-1:0]     in_timestamp,
  input  logic                             in_polarity,
  input  logic                             out_ready,
  output logic                             out_valid,
  output logic [DVS_X_ADDR_BITS-1:0]       out_x,
  output logic [DVS_Y_ADDR_BITS-1:0]       out_y,
  output logic [TIMESTAMP_US_BITS-1:0]     out_timestamp,
  output logic                             out_polarity,
  output logic [$clog2(FIFO_DEPTH):0]      fill_level,
  output logic                             full,
  output logic [DROP_CNT_BITS-1:0]         drop_count,
  input  logic                             clear_drops
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [DROP_CNT_BITS-1:0] DROP_MAX = '1;

  dvs_event_t mem [FIFO_DEPTH];
  dvs_event_t in_evt, head_q, head_nxt;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic        empty, push, pop, drop;

  assign in_evt = '{x: in_x, y: in_y, ts: in_timestamp, pol: in_polarity};

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign out_valid  = !empty;
  assign fill_level = wr_ptr - rd_ptr;

  assign pop  = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && !push;

  assign wr_ptr_nxt = wr_ptr + (AW+1)'(push);
  assign rd_ptr_nxt = rd_ptr + (AW+1)'(pop);

  // Next head: if the incoming event will be the only entry it cannot be read
  // from memory yet (written this same edge), so take it straight from the input.
  always_comb begin
    head_nxt = mem[rd_ptr_nxt[AW-1:0]];
    if (push && (rd_ptr_nxt == wr_ptr)) head_nxt = in_evt;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_evt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      head_q <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      // Only reload when something will be present; keeps out_* quiet when empty.
      if (wr_ptr_nxt != rd_ptr_nxt) head_q <= head_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (clear_drops) begin
      // The clear wins, but a drop in the same cycle is still recorded.
      drop_count <= drop ? DROP_CNT_BITS'(1) : '0;
    end else if (drop && (drop_count != DROP_MAX)) begin
      drop_count <= drop_count + 1'b1;
    end
  end

  assign out_x         = head_q.x;
  assign out_y         = head_q.y;
  assign out_timestamp = head_q.ts;
  assign out_polarity  = head_q.pol;

endmodule

// File: tb/tb_dvs_event_fifo.sv
// Testbench for dvs_event_fifo: directed scenarios plus a randomized phase,
// checked by a queue-based reference model and a negedge monitor.
module tb_dvs_event_fifo;
  import dvs_ravens_pkg::*;

  localparam int DEPTH = 16;
  localparam int DCB   = 4;
  localparam int DMAX  = (1 << DCB) - 1;

  logic                          clk, rst_n;
  logic                          in_valid, in_polarity, out_ready, clear_drops;
  logic [DVS_X_ADDR_BITS-1:0]    in_x, out_x;
  logic [DVS_Y_ADDR_BITS-1:0]    in_y, out_y;
  logic [TIMESTAMP_US_BITS-1:0]  in_timestamp, out_timestamp;
  logic                          out_valid, out_polarity, full;
  logic [$clog2(DEPTH):0]        fill_level;
  logic [DCB-1:0]                drop_count;

  dvs_event_fifo #(.FIFO_DEPTH(DEPTH), .DROP_CNT_BITS(DCB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
    .in_timestamp(in_timestamp), .in_polarity(in_polarity),
    .out_ready(out_ready), .out_valid(out_valid),
    .out_x(out_x), .out_y(out_y), .out_timestamp(out_timestamp),
    .out_polarity(out_polarity),
    .fill_level(fill_level), .full(full), .drop_count(drop_count),
    .clear_drops(clear_drops)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: the FIFO is a queue of accepted events, the drop
  // counter an integer with saturation.
  dvs_event_t sbq[$];
  int         exp_drop = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor + model update, both on negedge, when inputs and outputs are stable.
  always @(negedge clk) begin
    int         sz;
    bit         pop_m, push_m, drop_m;
    dvs_event_t e, got;
    got = '{x: out_x, y: out_y, ts: out_timestamp, pol: out_polarity};
    if (!rst_n) begin
      sbq.delete();
      exp_drop = 0;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_fill", 64'(fill_level), 64'(0));
    end else begin
      sz = sbq.size();
      chk("out_valid", 64'(out_valid), 64'(sz > 0));
      chk("fill_level", 64'(fill_level), 64'(sz));
      chk("full", 64'(full), 64'(sz == DEPTH));
      chk("drop_count", 64'(drop_count), 64'(exp_drop));
      pop_m = (sz > 0) && out_ready;
      if (pop_m) begin
        e = sbq.pop_front();
        chk("pop_data", 64'(got), 64'(e));
      end else if (sz > 0) begin
        chk("head_hold", 64'(got), 64'(sbq[0]));
      end
      push_m = in_valid && ((sz < DEPTH) || pop_m);
      drop_m = in_valid && !push_m;
      if (push_m) sbq.push_back('{x: in_x, y: in_y, ts: in_timestamp, pol: in_polarity});
      if (clear_drops)                  exp_drop = drop_m ? 1 : 0;
      else if (drop_m && exp_drop < DMAX) exp_drop = exp_drop + 1;
    end
  end

  function automatic dvs_event_t mk(input int x, input int y, input int ts, input bit pol);
    dvs_event_t e;
    e.x = DVS_X_ADDR_BITS'(x);
    e.y = DVS_Y_ADDR_BITS'(y);
    e.ts = TIMESTAMP_US_BITS'(ts);
    e.pol = pol;
    return e;
  endfunction

  function automatic dvs_event_t rnd_evt();
    return mk(int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
              int'($urandom), bit'($urandom_range(0, 1)));
  endfunction

  // Drive one cycle's inputs just after a posedge, then advance to the next.
  task automatic step(input bit v, input bit rdy, input bit clr, input dvs_event_t e);
    in_valid = v; out_ready = rdy; clear_drops = clr;
    in_x = e.x; in_y = e.y; in_timestamp = e.ts; in_polarity = e.pol;
    @(posedge clk); #1;
  endtask

  task automatic idle(input bit rdy, input int n);
    for (int i = 0; i < n; i++) step(1'b0, rdy, 1'b0, rnd_evt());
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clear_drops = 1'b0;
    in_x = '0; in_y = '0; in_timestamp = '0; in_polarity = 1'b0;
    #2;
    chk("reset_out_data", 64'({out_x, out_y, out_timestamp, out_polarity}), 64'(0));
    chk("reset_drop", 64'(drop_count), 64'(0));
    chk("reset_full", 64'(full), 64'(0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single event held while not ready, then consumed.
    step(1'b1, 1'b0, 1'b0, mk(5, 7, 100, 1'b1));
    chk("t1_latency_valid", 64'(out_valid), 64'(1));
    chk("t1_latency_data", 64'({out_x, out_y, out_timestamp, out_polarity}),
        64'(mk(5, 7, 100, 1'b1)));
    idle(1'b0, 10);
    idle(1'b1, 1);
    chk("t1_empty_after_pop", 64'(out_valid), 64'(0));
    idle(1'b0, 2);

    // Fill to 16, three drops, drain in order.
    for (int i = 0; i < DEPTH + 3; i++) step(1'b1, 1'b0, 1'b0, mk(i, i + 1, 1000 + i, i[0]));
    chk("t2_full", 64'(full), 64'(1));
    idle(1'b1, 1);
    chk("t2_full_deassert", 64'(full), 64'(0));
    idle(1'b1, DEPTH + 1);

    // Full with simultaneous push and pop.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, rnd_evt());
    step(1'b1, 1'b1, 1'b0, mk(77, 88, 999, 1'b1));
    chk("t3_still_full", 64'(fill_level), 64'(DEPTH));
    idle(1'b1, DEPTH + 1);

    // Continuous streaming across pointer wrap.
    for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 1'b0, rnd_evt());
    idle(1'b1, 2);

    // Drop counter saturation and clears.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, rnd_evt());
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, rnd_evt());
    chk("t5_saturate", 64'(drop_count), 64'(DMAX));
    step(1'b0, 1'b0, 1'b1, rnd_evt());
    chk("t5_clear", 64'(drop_count), 64'(0));
    step(1'b1, 1'b0, 1'b1, rnd_evt());
    chk("t5_clear_with_drop", 64'(drop_count), 64'(1));

    // Async reset with 9 entries buffered.
    idle(1'b1, DEPTH - 9);
    chk("t6_pre_fill", 64'(fill_level), 64'(9));
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 64'(out_valid), 64'(0));
    chk("t6_async_full", 64'(full), 64'(0));
    chk("t6_async_fill", 64'(fill_level), 64'(0));
    chk("t6_async_drop", 64'(drop_count), 64'(0));
    in_valid = 1'b0;
    @(posedge clk); #1;
    idle(1'b0, 1);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, mk(3, 4, 55, 1'b0));
    chk("t6_sole_fill", 64'(fill_level), 64'(1));
    idle(1'b0, 2);
    idle(1'b1, 2);

    // Randomized traffic with varying consumer pressure.
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 400; i++) begin
        step(bit'($urandom_range(0, 2) != 0),
             bit'($urandom_range(0, 3) < p + 1),
             bit'($urandom_range(0, 49) == 0), rnd_evt());
      end
    end
    idle(1'b1, DEPTH + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
